mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter; responder on the core's data-memory store interface, same byte-enable port shape as the data BRAM.
- Harts push bytes by storing to a TXDATA word and poll a STATUS word.
- Bytes are buffered in a FIFO and serialised 8N1, LSB first, on uart_txd.
- Sits beside the data BRAM in the top level; the address decode in the top level steers MMIO accesses here.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: bus shape, UART MMIO map, status bit layout, TX FSM states.
// No logic; constants, types and the baud divisor helper only.
// The default core clock comes from MMCM_OUT_FREQ_MHZ when the build does not set it.
`ifndef MMCM_OUT_FREQ_MHZ
`define MMCM_OUT_FREQ_MHZ 300
`endif

package riscv_pkg;
   localparam int DWIDTH = 32;
   localparam int NB_COL = DWIDTH / 8;

   // UART TX word offsets inside its MMIO window
   localparam int UART_TXDATA_OFFSET = 0;
   localparam int UART_STATUS_OFFSET = 1;

   // STATUS bit positions
   localparam int UART_STAT_FULL    = 0;
   localparam int UART_STAT_EMPTY   = 1;
   localparam int UART_STAT_ACTIVE  = 2;
   localparam int UART_STAT_OVF     = 3;
   localparam int UART_STAT_PAR     = 4;
   localparam int UART_STAT_CNT_LSB = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

   // Clock cycles per UART bit, rounded to nearest
   function automatic int uart_baud_div(input int mhz, input int baud);
      return (mhz * 1_000_000 + baud / 2) / baud;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output (dout valid whenever !empty).
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array needs no reset; empty hides stale contents
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA stores feed a FIFO, bytes go out 8N1 LSB first (8E1 with UART_TX_PARITY_EN).
// Latency: first start bit 2 cycles after the accepting store; STATUS read data 1 cycle after mmio_re.
// Backpressure: none on the bus; stores to a full FIFO are dropped and set the sticky overflow flag.
`ifndef MMCM_OUT_FREQ_MHZ
`define MMCM_OUT_FREQ_MHZ 300
`endif

module mmio_uart_tx
   import riscv_pkg::*;
#(
   parameter int CLK_FREQ_MHZ = `MMCM_OUT_FREQ_MHZ,
   parameter int BAUD_RATE    = 115200,
   parameter int FIFO_DEPTH   = 16,
   parameter int MMIO_AWIDTH  = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NB_COL-1:0]      mmio_we,
   input  logic                   mmio_re,
   input  logic [MMIO_AWIDTH-1:0] mmio_addr,
   input  logic [DWIDTH-1:0]      mmio_wdata,
   output logic [DWIDTH-1:0]      mmio_rdata,
   output logic                   uart_txd,
   output logic                   tx_busy
);
   localparam int DIV = uart_baud_div(CLK_FREQ_MHZ, BAUD_RATE);
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   if (DIV < 2) begin : g_bad_div
      $error("mmio_uart_tx: baud divisor below 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mmio_uart_tx: FIFO_DEPTH must be a power of 2 in 2..256");
   end

   uart_tx_state_t   state, state_nxt;
   logic [CW-1:0]    baud_cnt, baud_cnt_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [7:0]       shift, shift_nxt;
`ifdef UART_TX_PARITY_EN
   logic             par_bit, par_bit_nxt;
`endif
   logic             baud_end;
   logic             txd;

   logic             sel_txdata, sel_status;
   logic             push_req, push_ok, pop;
   logic             ovf_set, ovf_clr, ovf;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [FCW-1:0]   fifo_count;
   logic [DWIDTH-1:0] status;
   logic             unused_bits;

   assign sel_txdata = (mmio_addr == MMIO_AWIDTH'(UART_TXDATA_OFFSET));
   assign sel_status = (mmio_addr == MMIO_AWIDTH'(UART_STATUS_OFFSET));
   assign push_req   = mmio_we[0] && sel_txdata;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign push_ok    = push_req && (!fifo_full || pop);
   assign ovf_set    = push_req && !push_ok;
   assign ovf_clr    = mmio_we[0] && sel_status && mmio_wdata[UART_STAT_OVF];
   assign baud_end   = (baud_cnt == CW'(DIV - 1));
   assign uart_txd   = txd;
   assign tx_busy    = !fifo_empty || (state != IDLE);
   assign unused_bits = ^{mmio_wdata[DWIDTH-1:8], mmio_we[NB_COL-1:1]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_ok),
      .pop     (pop),
      .din     (mmio_wdata[7:0]),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // STATUS word as seen before this cycle's push/pop
   always_comb begin
      status = '0;
      status[UART_STAT_FULL]   = fifo_full;
      status[UART_STAT_EMPTY]  = fifo_empty;
      status[UART_STAT_ACTIVE] = (state != IDLE);
      status[UART_STAT_OVF]    = ovf;
`ifdef UART_TX_PARITY_EN
      status[UART_STAT_PAR]    = 1'b1;
`endif
      status[UART_STAT_CNT_LSB +: 8] = 8'(fifo_count);
   end

   // Sticky overflow flag, cleared by writing 1 to its STATUS bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   // Registered read data, held between reads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     mmio_rdata <= '0;
      else if (mmio_re) mmio_rdata <= sel_status ? status : '0;
   end

   // TX state register; reset returns the line high without waiting for a clock
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shift    <= shift_nxt;
`ifdef UART_TX_PARITY_EN
         par_bit  <= par_bit_nxt;
`endif
      end
   end

   // TX next-state and line drive; every non-IDLE state lasts DIV cycles per bit
   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_cnt_nxt  = bit_cnt;
      shift_nxt    = shift;
`ifdef UART_TX_PARITY_EN
      par_bit_nxt  = par_bit;
`endif
      txd          = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               shift_nxt    = fifo_dout;
`ifdef UART_TX_PARITY_EN
               par_bit_nxt  = ^fifo_dout;
`endif
               baud_cnt_nxt = '0;
               bit_cnt_nxt  = '0;
               state_nxt    = START;
            end
         end
         START: begin
            txd = 1'b0;
            if (baud_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            txd = shift[0];
            if (baud_end) begin
               baud_cnt_nxt = '0;
               shift_nxt    = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt   = PARITY;
`else
                  state_nxt   = STOP;
`endif
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            txd = par_bit;
            if (baud_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = STOP;
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            txd = 1'b1;
            if (baud_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = IDLE;
            end else begin
               baud_cnt_nxt = baud_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx at DIV=4, FIFO_DEPTH=4: table vectors, hand sequences, random traffic vs a queue model.
// Line model: each frame is a bit list (start, data LSB first, [parity], stop), each bit held DIV cycles.
// Builds for both parity settings (UART_TX_PARITY_EN).
module tb_mmio_uart_tx;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam logic [31:0] SPAR = 32'h10;
`else
   localparam int FRAME_BITS = 10;
   localparam logic [31:0] SPAR = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  mmio_we = '0;
   logic        mmio_re = 1'b0;
   logic [0:0]  mmio_addr = '0;
   logic [31:0] mmio_wdata = '0;
   logic [31:0] mmio_rdata;
   logic        uart_txd;
   logic        tx_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .CLK_FREQ_MHZ (1),
      .BAUD_RATE    (250000),
      .FIFO_DEPTH   (DEPTH),
      .MMIO_AWIDTH  (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mmio_we    (mmio_we),
      .mmio_re    (mmio_re),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_rdata (mmio_rdata),
      .uart_txd   (uart_txd),
      .tx_busy    (tx_busy)
   );

   // ---------------- reference model ----------------
   byte unsigned mq[$];
   bit           m_act;
   int           m_t;
   bit           m_bits[FRAME_BITS];
   bit           m_ovf;
   logic [31:0]  m_rdata;
   logic         exp_txd;
   logic         exp_busy;

   function automatic void model_reset();
      mq.delete();
      m_act = 0; m_t = 0; m_ovf = 0; m_rdata = '0;
      exp_txd = 1'b1; exp_busy = 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] we, input logic re, input logic addr,
                                      input logic [31:0] wd);
      bit          pop;
      logic [31:0] st;
      byte unsigned b;
      pop = !m_act && (mq.size() > 0);
      st = SPAR;
      st[0] = (mq.size() == DEPTH);
      st[1] = (mq.size() == 0);
      st[2] = m_act;
      st[3] = m_ovf;
      st[15:8] = 8'(mq.size());
      if (re) m_rdata = addr ? st : 32'h0;
      if (m_act) begin
         m_t++;
         if (m_t == FRAME_BITS * DIV) m_act = 0;
      end else if (pop) begin
         b = mq.pop_front();
         m_bits[0] = 1'b0;
         for (int i = 0; i < 8; i++) m_bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
         m_bits[9] = ^b;
`endif
         m_bits[FRAME_BITS - 1] = 1'b1;
         m_act = 1; m_t = 0;
      end
      if (we[0] && !addr) begin
         if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
         else m_ovf = 1;
      end
      if (we[0] && addr && wd[3]) m_ovf = 0;
      exp_txd  = m_act ? m_bits[m_t / DIV] : 1'b1;
      exp_busy = m_act || (mq.size() > 0);
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] we, input logic re, input logic addr, input logic [31:0] wd);
      mmio_we = we; mmio_re = re; mmio_addr = addr; mmio_wdata = wd;
      @(posedge clk); #1;
      cyc++;
      model_step(we, re, addr, wd);
      mmio_we = '0; mmio_re = 1'b0; mmio_wdata = '0;
      chk("txd", uart_txd, exp_txd);
      chk("busy", tx_busy, exp_busy);
      chk("rdata", mmio_rdata, m_rdata);
   endtask

   task automatic idle();
      step(4'b0000, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic drain();
      int n = 0;
      while ((tx_busy || exp_busy) && n < 2000) begin
         idle();
         n++;
      end
      chk("drain_timeout", {31'b0, tx_busy}, 32'h0);
   endtask

   // Start delay, stop bit, optional parity bit and frame length of one isolated byte
   task automatic frame_test(input logic [7:0] b);
      int n;
      step(4'b0001, 1'b0, 1'b0, {24'h0, b});
      chk("start_not_yet", uart_txd, 1'b1);
      idle();
      chk("start_bit", uart_txd, 1'b0);
      n = 0;
      while (tx_busy && n < 100) begin
         idle();
         n++;
         if (n == (FRAME_BITS - 1) * DIV) chk("stop_bit", uart_txd, 1'b1);
`ifdef UART_TX_PARITY_EN
         if (n == 9 * DIV) chk("parity_bit", uart_txd, ^b);
`endif
      end
      chk("frame_len", n, FRAME_BITS * DIV);
   endtask

   typedef struct {
      logic [3:0]  we;
      logic        re;
      logic        addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_txd;
      logic        exp_busy;
   } vec_t;

   vec_t vt[14];

   initial begin
      model_reset();
      // status reads, lane-1-only write, then 6 back-to-back pushes into a 4-deep FIFO
      vt[0]  = '{4'b0000, 1'b1, 1'b1, 32'h0,  32'h0002 | SPAR, 1'b1, 1'b0};
      vt[1]  = '{4'b0010, 1'b0, 1'b0, 32'h55, 32'h0002 | SPAR, 1'b1, 1'b0};
      vt[2]  = '{4'b0000, 1'b1, 1'b0, 32'h0,  32'h0000,        1'b1, 1'b0};
      vt[3]  = '{4'b0000, 1'b1, 1'b1, 32'h0,  32'h0002 | SPAR, 1'b1, 1'b0};
      vt[4]  = '{4'b0001, 1'b0, 1'b0, 32'h01, 32'h0002 | SPAR, 1'b1, 1'b1};
      vt[5]  = '{4'b0001, 1'b0, 1'b0, 32'h02, 32'h0002 | SPAR, 1'b0, 1'b1};
      vt[6]  = '{4'b0001, 1'b0, 1'b0, 32'h03, 32'h0002 | SPAR, 1'b0, 1'b1};
      vt[7]  = '{4'b0001, 1'b0, 1'b0, 32'h04, 32'h0002 | SPAR, 1'b0, 1'b1};
      vt[8]  = '{4'b0001, 1'b0, 1'b0, 32'h05, 32'h0002 | SPAR, 1'b0, 1'b1};
      vt[9]  = '{4'b0001, 1'b0, 1'b0, 32'h06, 32'h0002 | SPAR, 1'b1, 1'b1};
      vt[10] = '{4'b0000, 1'b1, 1'b1, 32'h0,  32'h040D | SPAR, 1'b1, 1'b1};
      vt[11] = '{4'b0001, 1'b0, 1'b1, 32'h8,  32'h040D | SPAR, 1'b1, 1'b1};
      vt[12] = '{4'b0000, 1'b1, 1'b1, 32'h0,  32'h0405 | SPAR, 1'b1, 1'b1};
      vt[13] = '{4'b0000, 1'b1, 1'b0, 32'h0,  32'h0000,        1'b0, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", uart_txd, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_rdata", mmio_rdata, 32'h0);
      reset_n = 1'b1;
      idle();

      // table vectors
      for (int i = 0; i < 14; i++) begin
         step(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata);
         chk($sformatf("vec%0d_rdata", i), mmio_rdata, vt[i].exp_rdata);
         chk($sformatf("vec%0d_txd", i), uart_txd, vt[i].exp_txd);
         chk($sformatf("vec%0d_busy", i), tx_busy, vt[i].exp_busy);
      end
      drain();
      step(4'b0000, 1'b1, 1'b1, 32'h0);
      chk("after_drain_status", mmio_rdata, 32'h0002 | SPAR);

      // single frame timing
      frame_test(8'hA5);
`ifdef UART_TX_PARITY_EN
      frame_test(8'h07);
`endif

      // reset during DATA bit 3
      step(4'b0001, 1'b0, 1'b0, 32'h5A);
      step(4'b0001, 1'b0, 1'b0, 32'h33);
      repeat (17) idle();
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_txd", uart_txd, 1'b1);
      chk("async_rst_busy", tx_busy, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      step(4'b0000, 1'b1, 1'b1, 32'h0);
      chk("post_rst_status", mmio_rdata, 32'h0002 | SPAR);

      // randomized traffic, busy phase then sparse phase
      for (int i = 0; i < 3000; i++) begin
         logic [3:0]  we;
         logic [31:0] wd;
         int rate;
         rate = (i < 1500) ? 4 : 40;
         we = ($urandom_range(0, rate - 1) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         wd = $urandom;
         step(we, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
